tohost_responder: RTL and testbench

//  Host-side end of the riscv-tests tohost/fromhost protocol for Sodor tiles.

---
 rtl/tohost_responder_pkg.sv | 31 +++
 rtl/tohost_responder_if.sv | 20 ++
 rtl/tohost_responder_watchdog.sv | 25 ++
 rtl/tohost_responder.sv | 137 +++++++++++++
 tb/tb_tohost_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tohost_responder_pkg.sv
// Shared types and constants for the Sodor tohost/fromhost host responder.
package sodor_host_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_ACK_WAIT = 3'd1,
    ST_PASS     = 3'd2,
    ST_FAIL     = 3'd3,
    ST_TIMEOUT  = 3'd4
  } host_state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_PASS = 2'd1,
    CMD_FAIL = 2'd2,
    CMD_HOST = 2'd3
  } tohost_cmd_e;

  localparam logic [31:0] TOHOST_ADDR_DEF   = 32'h8000_1000;
  localparam logic [31:0] FROMHOST_ADDR_DEF = 32'h8000_1040;
  localparam logic [31:0] TOHOST_PASS       = 32'd1;

  // riscv-tests encoding: 1 = pass, odd > 1 = fail code, even non-zero = host request
  function automatic tohost_cmd_e classify_tohost(input logic [31:0] v);
    if (v == '0)               return CMD_NONE;
    else if (v == TOHOST_PASS) return CMD_PASS;
    else if (v[0])             return CMD_FAIL;
    else                       return CMD_HOST;
  endfunction

endpackage

// File: rtl/tohost_responder_if.sv
// Core data-memory request/response bus as seen by the host responder.
interface tohost_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_addr, req_wr, req_data,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_wr, req_data,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/tohost_responder_watchdog.sv
// Saturating cycle counter since reset release and the watchdog expiry compare.
module host_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 600
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] cycle_count_o,
  output logic        expire_o
);
  localparam bit          WD_EN    = (TIMEOUT_CYC != 0);
  localparam logic [31:0] LIMIT_M1 = 32'(TIMEOUT_CYC - 1);

  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Fires in the last cycle before the limit so the terminal state lands on TIMEOUT_CYC
  assign expire_o      = WD_EN && (cnt_q == LIMIT_M1);
  assign cycle_count_o = cnt_q;
endmodule

// File: rtl/tohost_responder.sv
// Host end of the riscv-tests tohost/fromhost protocol: decodes tohost stores,
// acknowledges host requests through fromhost, and reports pass/fail/timeout.
module tohost_responder
  import sodor_host_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR   = TOHOST_ADDR_DEF,
  parameter logic [31:0] FROMHOST_ADDR = FROMHOST_ADDR_DEF,
  parameter int unsigned ACK_DELAY     = 4,
  parameter int unsigned TIMEOUT_CYC   = 600
) (
  input  logic                     clock,
  input  logic                     reset,
  tohost_responder_if.slave        bus,
  output logic                     test_done,
  output logic                     test_pass,
  output logic [30:0]              test_code,
  output logic                     timeout,
  output logic [31:0]              cycle_count
);
  localparam int                ACK_W    = (ACK_DELAY < 2) ? 1 : $clog2(ACK_DELAY + 1);
  localparam logic [ACK_W-1:0]  ACK_INIT = ACK_W'(ACK_DELAY);
  localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(1);

  host_state_e       state_q, state_d;
  logic [31:0]       tohost_q, tohost_d;
  logic [31:0]       fromhost_q, fromhost_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [30:0]       code_q, code_d;
  logic              ready_q, ready_d;
  logic              resp_vld_q, resp_vld_d;
  logic [31:0]       resp_data_q, resp_data_d;

  logic              expire;
  logic              acc, hit_to, hit_from, st_to, st_from, ld;
  tohost_cmd_e       cmd;

  host_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk_i         (clock),
    .rst_ni        (reset),
    .cycle_count_o (cycle_count),
    .expire_o      (expire)
  );

  assign acc      = bus.req_valid && bus.req_ready;
  assign hit_to   = (bus.req_addr == TOHOST_ADDR);
  assign hit_from = (bus.req_addr == FROMHOST_ADDR);
  assign st_to    = acc &&  bus.req_wr && hit_to;
  assign st_from  = acc &&  bus.req_wr && hit_from;
  assign ld       = acc && !bus.req_wr;
  assign cmd      = classify_tohost(bus.req_data);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Pass/fail stores take priority over a coinciding watchdog expiry; host requests do not
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if      (st_to && cmd == CMD_PASS) state_d = ST_PASS;
        else if (st_to && cmd == CMD_FAIL) state_d = ST_FAIL;
        else if (expire)                   state_d = ST_TIMEOUT;
        else if (st_to && cmd == CMD_HOST) state_d = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if      (expire)                 state_d = ST_TIMEOUT;
        else if (ack_cnt_q == ACK_LAST)  state_d = ST_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    test_done = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    test_pass = (state_q == ST_PASS);
    timeout   = (state_q == ST_TIMEOUT);
    test_code = code_q;
  end

  always_comb begin
    tohost_d    = tohost_q;
    fromhost_d  = fromhost_q;
    ack_cnt_d   = ack_cnt_q;
    code_d      = code_q;
    ready_d     = (state_d != ST_ACK_WAIT);
    resp_vld_d  = ld;
    resp_data_d = '0;

    if (ld) begin
      if      (hit_to)   resp_data_d = tohost_q;
      else if (hit_from) resp_data_d = fromhost_q;
    end

    if (state_q == ST_RUN) begin
      if (st_from) fromhost_d = bus.req_data;
      if (state_d == ST_ACK_WAIT) begin
        tohost_d  = bus.req_data;
        ack_cnt_d = ACK_INIT;
      end
      if (state_d == ST_FAIL) code_d = bus.req_data[31:1];
    end

    if (state_q == ST_ACK_WAIT) begin
      ack_cnt_d = ack_cnt_q - ACK_LAST;
      if (state_d == ST_RUN) begin
        tohost_d   = '0;
        fromhost_d = 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tohost_q    <= '0;
      fromhost_q  <= '0;
      ack_cnt_q   <= '0;
      code_q      <= '0;
      ready_q     <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      tohost_q    <= tohost_d;
      fromhost_q  <= fromhost_d;
      ack_cnt_q   <= ack_cnt_d;
      code_q      <= code_d;
      ready_q     <= ready_d;
      resp_vld_q  <= resp_vld_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_vld_q;
  assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_tohost_responder.sv
// Scenario tests plus a randomized load/store run against a timestamp-based host model.
module tb_tohost_responder;
  localparam logic [31:0] TO_A   = 32'h8000_1000;
  localparam logic [31:0] FROM_A = 32'h8000_1040;
  localparam int          ACKD   = 4;
  localparam int          TMO    = 600;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        test_done, test_pass, timeout;
  logic [30:0] test_code;
  logic [31:0] cycle_count;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  tohost_responder_if bus();

  tohost_responder #(
    .TOHOST_ADDR(TO_A), .FROMHOST_ADDR(FROM_A), .ACK_DELAY(ACKD), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .test_done(test_done), .test_pass(test_pass), .test_code(test_code),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got stuck, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock); #1; cyc++;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v; bus.req_wr = wr; bus.req_addr = a; bus.req_data = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1; cyc = 0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, '0);
    reset = 1'b0; #23;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b exp 0", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b exp 0", bus.resp_valid); end
    checks++; if ({test_done, test_pass, timeout} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b exp 000", {test_done, test_pass, timeout}); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL rst_cycle_count: got %0d exp 0", cycle_count); end
    do_reset(); step();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL run_ready: got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_pass_and_lock();
    do_reset();
    while (cyc < 50) step();
    drive(1'b1, 1'b1, TO_A, 32'd1);
    checks++; if (test_done !== 1'b0) begin failures++; $display("FAIL pass_done_early: got %b exp 0", test_done); end
    step(); drive(1'b0, 1'b0, '0, '0);
    checks++; if (cycle_count !== 32'd51) begin failures++; $display("FAIL pass_cycle: got %0d exp 51", cycle_count); end
    checks++; if ({test_done, test_pass} !== 2'b11) begin failures++; $display("FAIL pass_flags: got %b exp 11", {test_done, test_pass}); end
    checks++; if (timeout !== 1'b0 || test_code !== 31'd0) begin failures++; $display("FAIL pass_tmo_code: got %b/%0d exp 0/0", timeout, test_code); end
  endtask

  task automatic test_fail();
    do_reset(); step(); step();
    drive(1'b1, 1'b1, TO_A, 32'h7);
    step(); drive(1'b0, 1'b0, '0, '0);
    checks++; if ({test_done, test_pass} !== 2'b10) begin failures++; $display("FAIL fail_flags: got %b exp 10", {test_done, test_pass}); end
    checks++; if (test_code !== 31'd3) begin failures++; $display("FAIL fail_code: got %0d exp 3", test_code); end
  endtask

  task automatic test_ack();
    int n;
    do_reset(); step();
    drive(1'b1, 1'b1, TO_A, 32'h80);
    step(); drive(1'b0, 1'b0, '0, '0);
    n = 0;
    while (bus.req_ready === 1'b0 && n < 20) begin n++; step(); end
    checks++; if (n != ACKD) begin failures++; $display("FAIL ack_hold: got %0d cycles exp %0d", n, ACKD); end
    drive(1'b1, 1'b0, FROM_A, '0); step();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd1) begin failures++; $display("FAIL ack_fromhost: got %b/%0h exp 1/1", bus.resp_valid, bus.resp_data); end
    drive(1'b1, 1'b0, TO_A, '0); step(); drive(1'b0, 1'b0, '0, '0);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd0) begin failures++; $display("FAIL ack_tohost: got %b/%0h exp 1/0", bus.resp_valid, bus.resp_data); end
    step();
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL ack_resp_once: got %b exp 0", bus.resp_valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    while (cyc < TMO - 1) step();
    checks++; if ({test_done, timeout} !== 2'b00) begin failures++; $display("FAIL tmo_early: got %b exp 00", {test_done, timeout}); end
    step();
    checks++; if ({test_done, timeout, test_pass} !== 3'b110) begin failures++; $display("FAIL tmo_flags: got %b exp 110", {test_done, timeout, test_pass}); end
    checks++; if (cycle_count !== 32'(TMO)) begin failures++; $display("FAIL tmo_cycle: got %0d exp %0d", cycle_count, TMO); end
    repeat (5) step();
    checks++; if (cycle_count !== 32'(TMO + 5)) begin failures++; $display("FAIL tmo_keeps_counting: got %0d exp %0d", cycle_count, TMO + 5); end
  endtask

  task automatic test_pass_wins_expiry();
    do_reset();
    while (cyc < TMO - 1) step();
    drive(1'b1, 1'b1, TO_A, 32'd1);
    step();
    checks++; if ({test_done, test_pass, timeout} !== 3'b110) begin failures++; $display("FAIL race_pass: got %b exp 110", {test_done, test_pass, timeout}); end
    drive(1'b1, 1'b1, TO_A, 32'd3);
    step(); drive(1'b0, 1'b0, '0, '0); step();
    checks++; if ({test_done, test_pass, timeout} !== 3'b110 || test_code !== 31'd0) begin
      failures++; $display("FAIL after_pass_store: got %b code %0d exp 110 code 0", {test_done, test_pass, timeout}, test_code); end
  endtask

  task automatic test_reset_in_ack();
    do_reset(); step();
    drive(1'b1, 1'b1, TO_A, 32'h40);
    step(); drive(1'b0, 1'b0, '0, '0); step();
    reset = 1'b0; #1;
    checks++; if ({bus.req_ready, bus.resp_valid, test_done, test_pass, timeout} !== 5'b0 || test_code !== 31'd0 || cycle_count !== 32'd0) begin
      failures++; $display("FAIL mid_reset_outputs: got %b code %0d cnt %0d exp all 0", {bus.req_ready, bus.resp_valid, test_done, test_pass, timeout}, test_code, cycle_count); end
    @(negedge clock); reset = 1'b1; cyc = 0;
    step();
    drive(1'b1, 1'b0, FROM_A, '0); step(); drive(1'b0, 1'b0, '0, '0);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd0) begin failures++; $display("FAIL ack_dropped: got %b/%0h exp 1/0", bus.resp_valid, bus.resp_data); end
  endtask

  // Model: tohost/fromhost word values plus the cycle at which a pending acknowledge lands
  task automatic test_random();
    logic [31:0] to_m, from_m, exp_rd, v, a;
    logic        pending, exp_rv, exp_ready;
    int          ack_end, r;
    do_reset(); step();
    to_m = 0; from_m = 0; pending = 0; ack_end = -1; exp_rv = 0; exp_rd = 0;
    for (int op = 0; op < 80; op++) begin
      if (pending && cyc > ack_end) begin to_m = 0; from_m = 1; pending = 0; end
      exp_ready = !pending;
      checks++; if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready op%0d: got %b exp %b", op, bus.req_ready, exp_ready); end
      checks++; if (bus.resp_valid !== exp_rv || (exp_rv && bus.resp_data !== exp_rd)) begin
        failures++; $display("FAIL rnd_resp op%0d: got %b/%0h exp %b/%0h", op, bus.resp_valid, bus.resp_data, exp_rv, exp_rd); end
      exp_rv = 0;
      a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      r = exp_ready ? $urandom_range(0, 9) : 9;
      case (r)
        0, 1: begin drive(1'b1, 1'b0, TO_A, $urandom); exp_rv = 1; exp_rd = to_m; end
        2, 3: begin drive(1'b1, 1'b0, FROM_A, $urandom); exp_rv = 1; exp_rd = from_m; end
        4:    begin drive(1'b1, 1'b0, a, $urandom); exp_rv = 1; exp_rd = 0; end
        5:    begin v = $urandom; drive(1'b1, 1'b1, FROM_A, v); from_m = v; end
        6:    begin
                v = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFE);
                drive(1'b1, 1'b1, TO_A, v);
                if (v != 0) begin to_m = v; pending = 1; ack_end = cyc + ACKD; end
              end
        7:    drive(1'b1, 1'b1, a, $urandom);
        default: drive(1'b0, 1'b0, '0, '0);
      endcase
      step();
    end
    drive(1'b0, 1'b0, '0, '0);
    checks++; if (bus.resp_valid !== exp_rv || (exp_rv && bus.resp_data !== exp_rd)) begin
      failures++; $display("FAIL rnd_resp_last: got %b/%0h exp %b/%0h", bus.resp_valid, bus.resp_data, exp_rv, exp_rd); end
    checks++; if (cycle_count !== 32'(cyc)) begin failures++; $display("FAIL rnd_cycle: got %0d exp %0d", cycle_count, cyc); end
    repeat (ACKD + 1) step();
    v = $urandom | 32'h3;
    drive(1'b1, 1'b1, TO_A, v); step(); drive(1'b0, 1'b0, '0, '0);
    checks++; if ({test_done, test_pass} !== 2'b10 || test_code !== v[31:1]) begin
      failures++; $display("FAIL rnd_fail_code: got %b/%0h exp 10/%0h", {test_done, test_pass}, test_code, v[31:1]); end
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    test_reset();
    test_pass_and_lock();
    test_fail();
    test_ack();
    test_timeout();
    test_pass_wins_expiry();
    test_reset_in_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
